// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmit FSM states and a
// helper that sizes the baud timer from the clocks-per-bit setting.
package uart_pkg;

   // Parity selection values for the PARITY parameter.
   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Transmit frame sequencer states.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } tx_state_e;

   // Smallest counter width able to hold clocks_per_baud-1 (at least one bit).
   function automatic int unsigned timer_bits(input int unsigned clocks_per_baud);
      if (clocks_per_baud <= 32'd2) begin
         return 32'd1;
      end else begin
         return $clog2(clocks_per_baud);
      end
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO. Pointers carry one extra wrap bit so that a
// full FIFO and an empty FIFO are told apart without a separate flag.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic              do_push_s;
   logic              do_pop_s;

   // Requests are ignored when they cannot be honoured, so no data is lost on a full push.
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign count = wr_ptr_q - rd_ptr_q;
   assign rdata = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values: advance on an accepted push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array: written at the write pointer on an accepted push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else if (do_push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes arrive over valid/ready into a small
// FIFO and are sent as start, 8 data bits LSB first, optional parity and
// one or two stop bits. The line output is registered from the current
// state, so it trails the state register by one clock.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_BAUD = 868,
   parameter int TIMER_BITS      = 10,
   parameter int PARITY          = 0,
   parameter int STOP_BITS       = 1,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          i_reset_n,
   input  logic [7:0]                    i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   output logic                          o_txd,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_count
);
   localparam logic [TIMER_BITS-1:0] BAUD_LOAD  = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
   localparam logic [TIMER_BITS-1:0] BAUD_ZERO  = {TIMER_BITS{1'b0}};
   localparam logic [2:0]            LAST_STOP  = 3'(STOP_BITS - 1);
   localparam bit                    HAS_PARITY = (PARITY != PARITY_NONE);
   localparam bit                    ODD_PARITY = (PARITY == PARITY_ODD);
   localparam tx_state_e             AFTER_DATA = HAS_PARITY ? S_PARITY : S_STOP;

   tx_state_e              state_q, state_d;
   logic [TIMER_BITS-1:0]  baud_q, baud_d;
   logic [7:0]             shift_q, shift_d;
   logic [2:0]             bit_q, bit_d;
   logic                   par_q, par_d;
   logic                   txd_q, txd_d;
   logic                   busy_q, busy_d;

   logic                   fifo_pop_s;
   logic                   fifo_full_s;
   logic                   fifo_empty_s;
   logic [7:0]             fifo_rdata_s;
   logic                   bit_end_s;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (i_reset_n),
      .push  (i_valid),
      .wdata (i_data),
      .pop   (fifo_pop_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (o_count)
   );

   // Ready depends only on occupancy, never on a same-cycle pop.
   assign o_ready   = !fifo_full_s;
   assign o_txd     = txd_q;
   assign o_busy    = busy_q;
   assign bit_end_s = (baud_q == BAUD_ZERO);

   // Frame sequencer: state, baud timer, shift register, bit index and parity accumulator.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      shift_d    = shift_q;
      bit_d      = bit_q;
      par_d      = par_q;
      fifo_pop_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty_s) begin
               fifo_pop_s = 1'b1;
               shift_d    = fifo_rdata_s;
               bit_d      = 3'd0;
               par_d      = 1'b0;
               baud_d     = BAUD_LOAD;
               state_d    = S_START;
            end else begin
               baud_d     = BAUD_ZERO;
            end
         end
         S_START: begin
            if (bit_end_s) begin
               baud_d  = BAUD_LOAD;
               state_d = S_DATA;
            end else begin
               baud_d  = baud_q - TIMER_BITS'(1);
            end
         end
         S_DATA: begin
            if (bit_end_s) begin
               par_d   = par_q ^ shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
               baud_d  = BAUD_LOAD;
               if (bit_q == 3'd7) begin
                  bit_d   = 3'd0;
                  state_d = AFTER_DATA;
               end else begin
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               baud_d  = baud_q - TIMER_BITS'(1);
            end
         end
         S_PARITY: begin
            if (bit_end_s) begin
               bit_d   = 3'd0;
               baud_d  = BAUD_LOAD;
               state_d = S_STOP;
            end else begin
               baud_d  = baud_q - TIMER_BITS'(1);
            end
         end
         S_STOP: begin
            if (bit_end_s) begin
               if (bit_q == LAST_STOP) begin
                  if (!fifo_empty_s) begin
                     // Chain straight into the next start bit with no idle gap.
                     fifo_pop_s = 1'b1;
                     shift_d    = fifo_rdata_s;
                     bit_d      = 3'd0;
                     par_d      = 1'b0;
                     baud_d     = BAUD_LOAD;
                     state_d    = S_START;
                  end else begin
                     bit_d      = 3'd0;
                     baud_d     = BAUD_ZERO;
                     state_d    = S_IDLE;
                  end
               end else begin
                  bit_d  = bit_q + 3'd1;
                  baud_d = BAUD_LOAD;
               end
            end else begin
               baud_d = baud_q - TIMER_BITS'(1);
            end
         end
         default: begin
            baud_d  = BAUD_ZERO;
            state_d = S_IDLE;
         end
      endcase
   end

   // Line level for the bit currently being timed.
   always_comb begin
      txd_d = 1'b1;
      case (state_q)
         S_IDLE:   txd_d = 1'b1;
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_q[0];
         S_PARITY: txd_d = ODD_PARITY ? ~par_q : par_q;
         S_STOP:   txd_d = 1'b1;
         default:  txd_d = 1'b1;
      endcase
   end

   // Busy while a frame is in progress or bytes are still queued.
   always_comb begin
      busy_d = (state_d != S_IDLE) || !fifo_empty_s;
   end

   // Sequencer and output registers; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         baud_q  <= BAUD_ZERO;
         shift_q <= 8'h00;
         bit_q   <= 3'd0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: accepts bytes over a valid/ready handshake, queues them in a small FIFO and serialises each onto the line as a start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits. It is the transmit end of the board's UART link. It drives `uart_rxd_out` toward the host and pairs with the receive path that samples `uart_txd_in`.

## Interface
- `CLOCKS_PER_BAUD`, 868: clocks per bit; 868 gives 115200 baud at 100 MHz; must be ≥ 2.
- `TIMER_BITS`, 10: baud counter width; must hold `CLOCKS_PER_BAUD-1`.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries; power of two, ≥ 2.
- `clk` in 1: single clock, rising edge.
- `i_reset_n` in 1: reset is asynchronous and active-low.
- `i_data` in 8: byte to send.
- `i_valid` in 1: `i_data` valid.
- `o_ready` in→out 1: FIFO can accept; equals not-full.
- `o_txd` out 1: serial line, idle high.
- `o_busy` out 1: high while a frame is on the line or the FIFO is non-empty.
- `o_count` out log2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- Reset asserted: FIFO emptied, FSM set to IDLE, baud counter cleared. Outputs: `o_txd`=1, `o_ready`=1, `o_busy`=0, `o_count`=0. These take effect immediately, including mid-frame; a truncated frame is not resumed.
- Push: a byte is accepted on a rising edge when `i_valid && o_ready`. `o_ready` depends only on occupancy, never on a same-cycle pop.
- A push and a pop in the same cycle leave `o_count` unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when the FIFO is non-empty. The head is popped into an 8-bit shift register, and the bit index and parity accumulator are cleared.
- START: `o_txd`=0 for one bit time.
- DATA: `o_txd`=shift[0]; shift right once per bit; 8 bits.
- After DATA: go to PARITY if `PARITY`≠0, else to STOP.
- PARITY bit value:
  - even parity: XOR of the 8 data bits;
  - odd parity: its inverse.
- STOP: `o_txd`=1 for `STOP_BITS` bit times.
- At the end of STOP:
  - FIFO non-empty: pop and go directly to START, with no idle gap;
  - FIFO empty: go to IDLE.
- Baud counter: loaded with `CLOCKS_PER_BAUD-1` at each bit start and decremented each clock. The bit ends when the counter is 0. The counter never wraps below 0.
- `o_txd` is driven from a flop, so it is glitch-free.

## Timing
- Handshake edge N into an empty FIFO while IDLE: the pop occurs at edge N+1, and `o_txd` falls at edge N+2.
- Each bit lasts exactly `CLOCKS_PER_BAUD` clocks.
- Frame length is (10 + (PARITY≠0) + (STOP_BITS−1)) × `CLOCKS_PER_BAUD` clocks.
- Back-to-back frames: the next start bit begins on the edge that ends the last stop bit.
- `o_count` and `o_ready` update on the edge after a push or pop.
- `o_busy` falls on the same edge the FSM enters IDLE with the FIFO empty.
- Full FIFO: `o_ready`=0 and `i_valid` is ignored with no data loss. `o_ready` rises the edge after the pop.
- Empty FIFO: no pop is attempted and `o_txd` holds 1.

## Structure
- Shared package `uart_pkg` holds:
  - parity encoding constants (`PARITY_NONE`/`EVEN`/`ODD`);
  - the FSM state encoding;
  - a function computing timer width from `CLOCKS_PER_BAUD`.
- The receive path reuses the same package.
- Sub-module `uart_sync_fifo` is a generic synchronous FIFO, parameterised on width and depth.
  - Ports: `push`, `pop`, `full`, `empty`, `count`.
  - Pointers are one bit wider than the address so full and empty can be distinguished.
  - The FIFO uses the same asynchronous active-low reset.
- The top level contains the FSM, baud counter, shift register and parity logic.

## Test plan
All scenarios use `CLOCKS_PER_BAUD`=4 unless noted.
- Push 0xA5 with no parity and 1 stop bit: `o_txd` shows 0,1,0,1,0,0,1,0,1,1, each 4 clocks, starting 2 edges after the push. `o_busy` is high for 40 clocks.
- Push 0x03 with even parity, then with odd parity: the parity bit is 0, then 1. With `STOP_BITS`=2 the line stays high for 8 clocks before IDLE.
- Push 5 bytes (0x11–0x15) back-to-back with depth 4: `o_ready` drops after the FIFO fills. All 5 frames go out in order with no idle gap between stop and start. `o_count` returns to 0.
- Hold `i_valid` while full, with a changing `i_data`: no extra byte is accepted, and the byte presented on the edge after `o_ready` rises is sent next.
- Pulse `i_reset_n` low during data bit 3 of 0xFF: `o_txd`=1 asynchronously and the FIFO is empty. A new push of 0x55 afterwards sends a clean full frame.
- With defaults (868), push 0x00: each bit measures exactly 868 clocks.
